key_input_ctrl: RTL and testbench

- Front-panel input controller for the calendar. Turns four raw active-low pushbuttons into the mode code, set_dday flag and one-hot 15-bit field-select vector consumed by the 7-segment output stage, plus one-cycle increment and decrement pulses for the counter blocks.
- Covers the user-to-display direction: keys in, display and field control out.

---
 rtl/key_input_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_key_input_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_input_ctrl.sv
// key_input_ctrl: front-panel input controller for the calendar.
// Turns four active-low pushbuttons into the display mode code, the
// set_dday flag, a one-hot field cursor and one-cycle inc/dec pulses.
//
// Ports:
//   clock      system clock (single domain)
//   resetn     asynchronous active-low reset
//   key_n[3:0] raw buttons, active low: [0]=mode [1]=set/next [2]=up [3]=down
//   mode[2:0]  0=CLOCK 1=CLOCK_SET 2=DATE 3=DATE_SET 4=DDAY 5=DDAY_SET
//   set_dday   high only while mode=DDAY_SET
//   select     one-hot cursor: [2:0] clock, [8:3] date, [14:9] d-day; 0 in display modes
//   inc_pulse  one-cycle increment request for the selected field
//   dec_pulse  one-cycle decrement request for the selected field
//
// Optional feature macro: KEY_AUTO_REPEAT_EN (auto-repeat of held up/down
// keys in set modes). Undefined: exactly one pulse per press.
module key_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [3:0]  key_n,
  output logic [2:0]  mode,
  output logic        set_dday,
  output logic [14:0] select,
  output logic        inc_pulse,
  output logic        dec_pulse
);

  localparam int unsigned KEYS = 4;
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // Top cursor bit of each group: select[2], select[8], select[14].
  localparam logic [14:0] TOP_MASK = 15'h4104;

  typedef enum logic [2:0] {
    ST_CLOCK     = 3'd0,
    ST_CLOCK_SET = 3'd1,
    ST_DATE      = 3'd2,
    ST_DATE_SET  = 3'd3,
    ST_DDAY      = 3'd4,
    ST_DDAY_SET  = 3'd5
  } state_t;

  logic [KEYS-1:0] r_sync1, r_sync2, r_db, r_press;
  logic [DB_W-1:0] r_db_cnt [KEYS];
  logic [KEYS-1:0] w_lvl, w_flip;

  state_t      r_state, w_state_nxt;
  logic [14:0] r_select, w_select_nxt;
  logic        r_inc, r_dec, r_set_dday;
  logic        w_inc_nxt, w_dec_nxt;

  logic w_hi, w_ev_set, w_ev_mode, w_ev_up, w_ev_dn;
  logic w_in_set, w_at_top;
  logic w_rpt_up, w_rpt_dn;

  // Synchronized level, 1 = pressed.
  assign w_lvl = ~r_sync2;

  // A key flips once its new level has held for DEBOUNCE_CYCLES cycles.
  always_comb begin
    w_flip = '0;
    for (int unsigned k = 0; k < KEYS; k++) begin
      w_flip[k] = (w_lvl[k] != r_db[k]) && (r_db_cnt[k] == DB_W'(DEBOUNCE_CYCLES - 1));
    end
  end

  // Synchronizers, debounce counters and press strobes.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_db    <= '0;
      r_press <= '0;
      for (int unsigned k = 0; k < KEYS; k++) r_db_cnt[k] <= '0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_press <= w_flip & ~r_db;
      for (int unsigned k = 0; k < KEYS; k++) begin
        if (w_lvl[k] == r_db[k]) begin
          r_db_cnt[k] <= '0;
        end else if (w_flip[k]) begin
          r_db_cnt[k] <= '0;
          r_db[k]     <= w_lvl[k];
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  // Event priority set > mode > up > down; up+down together cancel.
  assign w_ev_set  = r_press[1];
  assign w_ev_mode = r_press[0] & ~r_press[1];
  assign w_hi      = r_press[1] | r_press[0];
  assign w_ev_up   = r_press[2] & ~r_press[3] & ~w_hi;
  assign w_ev_dn   = r_press[3] & ~r_press[2] & ~w_hi;

  // Set states are exactly the odd mode codes.
  assign w_in_set = r_state[0];
  assign w_at_top = |(r_select & TOP_MASK);

`ifdef KEY_AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  logic             r_rpt_act, r_rpt_dn, r_rpt_first;
  logic [RPT_W-1:0] r_rpt_cnt;
  logic             w_rpt_held, w_rpt_stop, w_rpt_fire, w_rpt_new;
  logic [RPT_W-1:0] w_rpt_lim;

  assign w_rpt_new  = w_in_set & (w_ev_up | w_ev_dn);
  assign w_rpt_held = r_rpt_dn ? r_db[3] : r_db[2];
  assign w_rpt_stop = ~w_in_set | w_hi | ~w_rpt_held | (r_db[2] & r_db[3]);
  assign w_rpt_lim  = r_rpt_first ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1);
  assign w_rpt_fire = r_rpt_act & ~w_rpt_stop & ~w_rpt_new & (r_rpt_cnt == w_rpt_lim);
  assign w_rpt_up   = w_rpt_fire & ~r_rpt_dn;
  assign w_rpt_dn   = w_rpt_fire & r_rpt_dn;

  // Repeat timer: armed by an up/down press, first interval REPEAT_DELAY then REPEAT_PERIOD.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rpt_act   <= 1'b0;
      r_rpt_dn    <= 1'b0;
      r_rpt_first <= 1'b0;
      r_rpt_cnt   <= '0;
    end else if (w_rpt_new) begin
      r_rpt_act   <= 1'b1;
      r_rpt_dn    <= w_ev_dn;
      r_rpt_first <= 1'b1;
      r_rpt_cnt   <= '0;
    end else if (w_rpt_stop) begin
      r_rpt_act <= 1'b0;
      r_rpt_cnt <= '0;
    end else if (r_rpt_act) begin
      if (w_rpt_fire) begin
        r_rpt_cnt   <= '0;
        r_rpt_first <= 1'b0;
      end else begin
        r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
      end
    end
  end
`else
  assign w_rpt_up = 1'b0;
  assign w_rpt_dn = 1'b0;
  if ((REPEAT_DELAY == 0) || (REPEAT_PERIOD == 0)) begin : g_rpt_cfg_unused
  end
`endif

  // Mode FSM next-state and registered-output values.
  always_comb begin
    w_state_nxt  = r_state;
    w_select_nxt = r_select;
    w_inc_nxt    = 1'b0;
    w_dec_nxt    = 1'b0;
    case (r_state)
      ST_CLOCK: begin
        if (w_ev_set) begin
          w_state_nxt  = ST_CLOCK_SET;
          w_select_nxt = 15'h0001;
        end else if (w_ev_mode) begin
          w_state_nxt = ST_DATE;
        end
      end
      ST_DATE: begin
        if (w_ev_set) begin
          w_state_nxt  = ST_DATE_SET;
          w_select_nxt = 15'h0008;
        end else if (w_ev_mode) begin
          w_state_nxt = ST_DDAY;
        end
      end
      ST_DDAY: begin
        if (w_ev_set) begin
          w_state_nxt  = ST_DDAY_SET;
          w_select_nxt = 15'h0200;
        end else if (w_ev_mode) begin
          w_state_nxt = ST_CLOCK;
        end
      end
      ST_CLOCK_SET, ST_DATE_SET, ST_DDAY_SET: begin
        if (w_ev_set) begin
          if (w_at_top) begin
            // Clearing bit 0 of the code yields the matching display state.
            w_state_nxt  = state_t'({r_state[2:1], 1'b0});
            w_select_nxt = '0;
          end else begin
            w_select_nxt = {r_select[13:0], 1'b0};
          end
        end else begin
          w_inc_nxt = w_ev_up | w_rpt_up;
          w_dec_nxt = w_ev_dn | w_rpt_dn;
        end
      end
      default: begin
        w_state_nxt  = ST_CLOCK;
        w_select_nxt = '0;
      end
    endcase
  end

  // Mode state and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_CLOCK;
      r_select   <= '0;
      r_inc      <= 1'b0;
      r_dec      <= 1'b0;
      r_set_dday <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_select   <= w_select_nxt;
      r_inc      <= w_inc_nxt;
      r_dec      <= w_dec_nxt;
      r_set_dday <= (w_state_nxt == ST_DDAY_SET);
    end
  end

  assign mode      = r_state;
  assign set_dday  = r_set_dday;
  assign select    = r_select;
  assign inc_pulse = r_inc;
  assign dec_pulse = r_dec;

endmodule

// File: tb/tb_key_input_ctrl.sv
// Directed bench for key_input_ctrl with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=8. Honors KEY_AUTO_REPEAT_EN.
module tb_key_input_ctrl;

  logic        clock;
  logic        resetn;
  logic [3:0]  key_n;
  logic [2:0]  mode;
  logic        set_dday;
  logic [14:0] select;
  logic        inc_pulse;
  logic        dec_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  int inc_hi, inc_runs, dec_hi, dec_runs, inv_bad;
  logic prev_inc, prev_dec;

`ifdef KEY_AUTO_REPEAT_EN
  // Held 50 cycles: press pulse, one after 20 cycles, then every 8 cycles.
  localparam int EXP_HOLD_PULSES = 1 + 1 + (50 - 20) / 8;
`else
  localparam int EXP_HOLD_PULSES = 1;
`endif

  key_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .key_n    (key_n),
    .mode     (mode),
    .set_dday (set_dday),
    .select   (select),
    .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] group_mask(input logic [2:0] m);
    case (m)
      3'd1:    group_mask = 15'h0007;
      3'd3:    group_mask = 15'h01F8;
      3'd5:    group_mask = 15'h7E00;
      default: group_mask = 15'h0000;
    endcase
  endfunction

  task automatic clear_counts();
    inc_hi = 0; inc_runs = 0; dec_hi = 0; dec_runs = 0;
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (inc_pulse === 1'b1) begin
        inc_hi++;
        if (prev_inc !== 1'b1) inc_runs++;
      end
      if (dec_pulse === 1'b1) begin
        dec_hi++;
        if (prev_dec !== 1'b1) dec_runs++;
      end
      prev_inc = inc_pulse;
      prev_dec = dec_pulse;
      if (!$onehot0(select) || ((select & ~group_mask(mode)) != 15'h0) || (mode > 3'd5))
        inv_bad++;
    end
  endtask

  task automatic press(input int k);
    key_n[k] = 1'b0;
    step(10);
    key_n[k] = 1'b1;
    step(10);
  endtask

  initial begin
    inv_bad = 0;
    prev_inc = 1'b0;
    prev_dec = 1'b0;
    clear_counts();
    key_n  = 4'hF;
    resetn = 1'b0;
    step(3);
    check("reset_mode", 32'(mode), 32'd0);
    check("reset_select", 32'(select), 32'd0);

    // Idle after reset release.
    resetn = 1'b1;
    clear_counts();
    step(20);
    check("idle_mode", 32'(mode), 32'd0);
    check("idle_select", 32'(select), 32'd0);
    check("idle_set_dday", 32'(set_dday), 32'd0);
    check("idle_pulses", 32'(inc_hi + dec_hi), 32'd0);

    // Mode key cycles CLOCK -> DATE -> DDAY -> CLOCK.
    press(0);
    check("mode_to_date", 32'(mode), 32'd2);
    check("mode_date_sel", 32'(select), 32'd0);
    press(0);
    check("mode_to_dday", 32'(mode), 32'd4);
    press(0);
    check("mode_to_clock", 32'(mode), 32'd0);
    check("mode_clock_sel", 32'(select), 32'd0);

    // Walk the clock cursor and wrap back to display.
    press(1);
    check("cset1_mode", 32'(mode), 32'd1);
    check("cset1_sel", 32'(select), 32'h0001);
    press(1);
    check("cset2_sel", 32'(select), 32'h0002);
    press(1);
    check("cset3_sel", 32'(select), 32'h0004);
    press(1);
    check("cset_exit_mode", 32'(mode), 32'd0);
    check("cset_exit_sel", 32'(select), 32'h0000);

    // DDAY_SET: up twice, down once.
    press(0);
    press(0);
    check("dday_mode", 32'(mode), 32'd4);
    check("dday_set_dday", 32'(set_dday), 32'd0);
    press(1);
    check("dset_mode", 32'(mode), 32'd5);
    check("dset_set_dday", 32'(set_dday), 32'd1);
    check("dset_sel", 32'(select), 32'h0200);
    clear_counts();
    press(2);
    press(2);
    press(3);
    check("dset_inc_cycles", 32'(inc_hi), 32'd2);
    check("dset_inc_runs", 32'(inc_runs), 32'd2);
    check("dset_dec_cycles", 32'(dec_hi), 32'd1);
    check("dset_dec_runs", 32'(dec_runs), 32'd1);
    check("dset_sel_kept", 32'(select), 32'h0200);

    // Mode key ignored in a set state.
    press(0);
    check("dset_mode_ignored", 32'(mode), 32'd5);

    // Walk d-day cursor to its top bit and exit.
    for (int i = 0; i < 5; i++) press(1);
    check("dset_top_sel", 32'(select), 32'h4000);
    press(1);
    check("dset_exit_mode", 32'(mode), 32'd4);
    check("dset_exit_sel", 32'(select), 32'h0000);
    check("dset_exit_set_dday", 32'(set_dday), 32'd0);

    // Back to CLOCK_SET with select[0].
    press(0);
    press(1);
    check("cset_again_sel", 32'(select), 32'h0001);

    // Short glitch on set is filtered.
    key_n[1] = 1'b0;
    step(2);
    key_n[1] = 1'b1;
    step(12);
    check("glitch_mode", 32'(mode), 32'd1);
    check("glitch_sel", 32'(select), 32'h0001);

    // Set and up together: set wins, up discarded.
    clear_counts();
    key_n[1] = 1'b0;
    key_n[2] = 1'b0;
    step(10);
    key_n[1] = 1'b1;
    key_n[2] = 1'b1;
    step(10);
    check("setup_sel", 32'(select), 32'h0002);
    check("setup_no_inc", 32'(inc_hi), 32'd0);

    // Up and down together in a set state: nothing.
    key_n[2] = 1'b0;
    key_n[3] = 1'b0;
    step(10);
    key_n[2] = 1'b1;
    key_n[3] = 1'b1;
    step(10);
    check("updown_no_pulse", 32'(inc_hi + dec_hi), 32'd0);

    // Leave clock set, go to DATE_SET.
    press(1);
    press(1);
    check("cset_exit2_mode", 32'(mode), 32'd0);
    press(0);
    press(1);
    check("dtset_mode", 32'(mode), 32'd3);
    check("dtset_sel", 32'(select), 32'h0008);

    // Hold up for 50 cycles.
    clear_counts();
    key_n[2] = 1'b0;
    step(50);
    key_n[2] = 1'b1;
    step(12);
    check("hold_inc_cycles", 32'(inc_hi), 32'(EXP_HOLD_PULSES));
    check("hold_inc_runs", 32'(inc_runs), 32'(EXP_HOLD_PULSES));
    check("hold_no_dec", 32'(dec_hi), 32'd0);

    // Reset asserted mid-hold forces reset values at once.
    key_n[2] = 1'b0;
    step(30);
    check("midhold_mode", 32'(mode), 32'd3);
    check("midhold_sel", 32'(select), 32'h0008);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_mode", 32'(mode), 32'd0);
    check("async_rst_sel", 32'(select), 32'd0);
    check("async_rst_set_dday", 32'(set_dday), 32'd0);
    check("async_rst_pulses", 32'({inc_pulse, dec_pulse}), 32'd0);

    // Mode key held through reset release gives one press after debounce.
    key_n[2] = 1'b1;
    key_n[0] = 1'b0;
    step(3);
    resetn = 1'b1;
    step(15);
    check("held_thru_rst_mode", 32'(mode), 32'd2);
    key_n[0] = 1'b1;
    step(10);
    check("release_no_event", 32'(mode), 32'd2);
    check("release_sel", 32'(select), 32'd0);

    check("select_invariant", 32'(inv_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
